spi_flash_seq: RTL and testbench

- Command sequencer directly upstream of the SPI master; turns one user request (read, page program, sector erase, read status) into the complete serial-flash transaction sequence.
- Sequences: write-enable, then main op, then status-register polling until WIP clears.
- Drives the master's start/cmd/addr/length interface, forwards its write-data request and read-data strobes to the user side, and reports done/error.

---
 rtl/spi_flash_pkg.sv | 38 +++
 rtl/spi_flash_poll_timer.sv | 42 ++++
 rtl/spi_flash_seq.sv | 219 +++++++++++++++++++++
 tb/tb_spi_flash_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared opcodes, user op encodings and sequencer state encoding for the
// serial-flash command sequencer.
package spi_flash_pkg;

  localparam logic [7:0] OPC_WREN = 8'h06;
  localparam logic [7:0] OPC_READ = 8'h03;
  localparam logic [7:0] OPC_PP   = 8'h02;
  localparam logic [7:0] OPC_SE   = 8'h20;
  localparam logic [7:0] OPC_RDSR = 8'h05;

  // Cycles to wait for m_busy to rise after m_start before giving up.
  localparam logic [2:0] HS_TIMEOUT = 3'd4;

  typedef enum logic [1:0] {
    OP_READ = 2'd0,
    OP_PP   = 2'd1,
    OP_SE   = 2'd2,
    OP_RDSR = 2'd3
  } usr_op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WREN_ISSUE,
    S_WREN_WAIT,
    S_OP_ISSUE,
    S_OP_WAIT,
    S_GAP,
    S_POLL_ISSUE,
    S_POLL_WAIT,
    S_POLL_CHK,
    S_DONE
  } state_e;

  function automatic logic needs_wren(input usr_op_e op);
    return (op == OP_PP) || (op == OP_SE);
  endfunction

endpackage

// File: rtl/spi_flash_poll_timer.sv
// Inter-poll gap counter and RDSR poll counter for the flash sequencer.
module spi_flash_poll_timer #(
  parameter int POLL_GAP = 100,
  parameter int POLL_MAX = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_gap_start,
  input  logic i_gap_run,
  input  logic i_poll,
  output logic o_expire,
  output logic o_timeout
);

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
  localparam int PW = $clog2(POLL_MAX + 1);

  logic [GW-1:0] r_gap_cnt;
  logic [PW-1:0] r_poll_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap_cnt  <= '0;
      r_poll_cnt <= '0;
    end else begin
      if (i_gap_start)
        r_gap_cnt <= '0;
      else if (i_gap_run && !o_expire)
        r_gap_cnt <= r_gap_cnt + 1'b1;
      // saturate so a stuck WIP never wraps the count back to zero
      if (i_clr)
        r_poll_cnt <= '0;
      else if (i_poll && !o_timeout)
        r_poll_cnt <= r_poll_cnt + 1'b1;
    end
  end

  assign o_expire  = i_gap_run && (r_gap_cnt == GW'(POLL_GAP - 1));
  assign o_timeout = (r_poll_cnt == PW'(POLL_MAX));

endmodule

// File: rtl/spi_flash_seq.sv
// Serial-flash command sequencer: WREN, main op, then RDSR polling until WIP
// clears, driving an SPI master and reporting done/error to the user.
module spi_flash_seq
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_WIDTH = 24,
  parameter int          POLL_GAP   = 100,
  parameter int          POLL_MAX   = 65535,
  parameter logic [7:0]  CMD_WREN   = OPC_WREN,
  parameter logic [7:0]  CMD_READ   = OPC_READ,
  parameter logic [7:0]  CMD_PP     = OPC_PP,
  parameter logic [7:0]  CMD_SE     = OPC_SE,
  parameter logic [7:0]  CMD_RDSR   = OPC_RDSR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  usr_start,
  input  logic [1:0]            usr_op,
  input  logic [ADDR_WIDTH-1:0] usr_addr,
  input  logic [11:0]           usr_length,
  input  logic [7:0]            usr_wr_data,
  output logic                  usr_wr_req,
  output logic [7:0]            usr_rd_data,
  output logic                  usr_rd_vld,
  output logic                  usr_busy,
  output logic                  usr_done,
  output logic                  usr_err,
  output logic [7:0]            usr_status,
  output logic                  m_start,
  output logic [7:0]            m_cmd,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [11:0]           m_length,
  output logic                  m_cmd_only,
  output logic [7:0]            m_wr_data,
  input  logic                  m_wr_req,
  input  logic [7:0]            m_rd_data,
  input  logic                  m_rd_vld,
  input  logic                  m_busy
);

  state_e                r_state;
  usr_op_e               r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [11:0]           r_len;
  logic                  r_seen_busy;
  logic [2:0]            r_hs_cnt;
  logic                  r_m_start, r_m_cmd_only, r_busy, r_done, r_err, r_rd_vld;
  logic [7:0]            r_m_cmd, r_status, r_rd_data;
  logic [ADDR_WIDTH-1:0] r_m_addr;
  logic [11:0]           r_m_length;

  logic w_accept, w_bad_len, w_in_wait, w_busy_fall, w_hs_timeout;
  logic w_rd_phase, w_gap_start, w_gap_expire, w_poll_timeout;

  assign w_accept     = (r_state == S_IDLE) && usr_start && !r_busy;
  assign w_bad_len    = (usr_length == 12'd0) || (usr_length > 12'd256);
  assign w_in_wait    = (r_state == S_WREN_WAIT) || (r_state == S_OP_WAIT) ||
                        (r_state == S_POLL_WAIT);
  assign w_busy_fall  = r_seen_busy && !m_busy;
  assign w_hs_timeout = !r_seen_busy && !m_busy && (r_hs_cnt == HS_TIMEOUT);
  assign w_rd_phase   = (r_state == S_OP_WAIT) && ((r_op == OP_READ) || (r_op == OP_RDSR));
  assign w_gap_start  = ((r_state == S_OP_WAIT) && w_busy_fall && needs_wren(r_op)) ||
                        ((r_state == S_POLL_CHK) && r_status[0] && !w_poll_timeout);

  spi_flash_poll_timer #(.POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_accept),
    .i_gap_start(w_gap_start),
    .i_gap_run  (r_state == S_GAP),
    .i_poll     (r_state == S_POLL_ISSUE),
    .o_expire   (w_gap_expire),
    .o_timeout  (w_poll_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= OP_READ;
      r_addr       <= '0;
      r_len        <= '0;
      r_seen_busy  <= 1'b0;
      r_hs_cnt     <= '0;
      r_m_start    <= 1'b0;
      r_m_cmd      <= '0;
      r_m_addr     <= '0;
      r_m_length   <= '0;
      r_m_cmd_only <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_status     <= '0;
      r_rd_data    <= '0;
      r_rd_vld     <= 1'b0;
    end else begin
      r_m_start <= 1'b0;
      r_done    <= 1'b0;
      r_rd_vld  <= m_rd_vld && w_rd_phase;
      if (m_rd_vld && w_rd_phase)
        r_rd_data <= m_rd_data;
      if (m_rd_vld && ((r_state == S_POLL_WAIT) || (w_rd_phase && r_op == OP_RDSR)))
        r_status <= m_rd_data;
      // handshake watchdog: counts until the master acknowledges with m_busy
      if (w_in_wait && !r_seen_busy) begin
        if (m_busy)
          r_seen_busy <= 1'b1;
        else if (r_hs_cnt != HS_TIMEOUT)
          r_hs_cnt <= r_hs_cnt + 3'd1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= usr_op_e'(usr_op);
            r_addr <= usr_addr;
            r_len  <= usr_length;
            r_busy <= 1'b1;
            r_err  <= 1'b0;
            if (usr_op_e'(usr_op) == OP_PP && w_bad_len) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else if (needs_wren(usr_op_e'(usr_op)))
              r_state <= S_WREN_ISSUE;
            else
              r_state <= S_OP_ISSUE;
          end else
            r_busy <= 1'b0;
        end
        S_WREN_ISSUE: begin
          r_m_start    <= 1'b1;
          r_m_cmd      <= CMD_WREN;
          r_m_addr     <= '0;
          r_m_length   <= '0;
          r_m_cmd_only <= 1'b1;
          r_seen_busy  <= 1'b0;
          r_hs_cnt     <= '0;
          r_state      <= S_WREN_WAIT;
        end
        S_WREN_WAIT: begin
          if (w_hs_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (w_busy_fall)
            r_state <= S_OP_ISSUE;
        end
        S_OP_ISSUE: begin
          r_m_start    <= 1'b1;
          r_m_addr     <= r_addr;
          r_m_cmd_only <= 1'b0;
          r_seen_busy  <= 1'b0;
          r_hs_cnt     <= '0;
          unique case (r_op)
            OP_READ: begin r_m_cmd <= CMD_READ; r_m_length <= r_len;  end
            OP_PP:   begin r_m_cmd <= CMD_PP;   r_m_length <= r_len;  end
            OP_SE:   begin r_m_cmd <= CMD_SE;   r_m_length <= 12'd0;  end
            OP_RDSR: begin r_m_cmd <= CMD_RDSR; r_m_length <= 12'd1;  end
            default: begin r_m_cmd <= CMD_READ; r_m_length <= r_len;  end
          endcase
          r_state <= S_OP_WAIT;
        end
        S_OP_WAIT: begin
          if (w_hs_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (w_busy_fall)
            r_state <= needs_wren(r_op) ? S_GAP : S_DONE;
        end
        S_GAP:
          if (w_gap_expire) r_state <= S_POLL_ISSUE;
        S_POLL_ISSUE: begin
          r_m_start    <= 1'b1;
          r_m_cmd      <= CMD_RDSR;
          r_m_addr     <= '0;
          r_m_length   <= 12'd1;
          r_m_cmd_only <= 1'b0;
          r_seen_busy  <= 1'b0;
          r_hs_cnt     <= '0;
          r_state      <= S_POLL_WAIT;
        end
        S_POLL_WAIT: begin
          if (w_hs_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (w_busy_fall)
            r_state <= S_POLL_CHK;
        end
        S_POLL_CHK: begin
          if (!r_status[0])
            r_state <= S_DONE;
          else if (w_poll_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else
            r_state <= S_GAP;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign usr_wr_req  = m_wr_req && (r_state == S_OP_WAIT) && (r_op == OP_PP);
  assign m_wr_data   = usr_wr_data;
  assign usr_rd_data = r_rd_data;
  assign usr_rd_vld  = r_rd_vld;
  assign usr_busy    = r_busy;
  assign usr_done    = r_done;
  assign usr_err     = r_err;
  assign usr_status  = r_status;
  assign m_start     = r_m_start;
  assign m_cmd       = r_m_cmd;
  assign m_addr      = r_m_addr;
  assign m_length    = r_m_length;
  assign m_cmd_only  = r_m_cmd_only;

endmodule

// File: tb/tb_spi_flash_seq.sv
// Directed bench for spi_flash_seq with a behavioural SPI-master model.
module tb_spi_flash_seq;

  localparam int AW   = 24;
  localparam int GAP  = 10;
  localparam int PMAX = 8;

  logic          clk = 1'b0, rst = 1'b1;
  logic          usr_start = 1'b0;
  logic [1:0]    usr_op = 2'd0;
  logic [AW-1:0] usr_addr = '0;
  logic [11:0]   usr_length = '0;
  logic [7:0]    usr_wr_data = 8'h00;
  logic          usr_wr_req, usr_rd_vld, usr_busy, usr_done, usr_err;
  logic [7:0]    usr_rd_data, usr_status;
  logic          m_start, m_cmd_only;
  logic [7:0]    m_cmd, m_wr_data;
  logic [AW-1:0] m_addr;
  logic [11:0]   m_length;
  logic          m_wr_req = 1'b0, m_rd_vld = 1'b0, m_busy = 1'b0;
  logic [7:0]    m_rd_data = 8'h00;

  always #5 clk = ~clk;

  spi_flash_seq #(.ADDR_WIDTH(AW), .POLL_GAP(GAP), .POLL_MAX(PMAX)) dut (
    .clk(clk), .rst(rst), .usr_start(usr_start), .usr_op(usr_op), .usr_addr(usr_addr),
    .usr_length(usr_length), .usr_wr_data(usr_wr_data), .usr_wr_req(usr_wr_req),
    .usr_rd_data(usr_rd_data), .usr_rd_vld(usr_rd_vld), .usr_busy(usr_busy),
    .usr_done(usr_done), .usr_err(usr_err), .usr_status(usr_status), .m_start(m_start),
    .m_cmd(m_cmd), .m_addr(m_addr), .m_length(m_length), .m_cmd_only(m_cmd_only),
    .m_wr_data(m_wr_data), .m_wr_req(m_wr_req), .m_rd_data(m_rd_data),
    .m_rd_vld(m_rd_vld), .m_busy(m_busy)
  );

  int n_vec = 0, n_bad = 0, cyc = 0, done_cnt = 0, wr_idx = 0;
  logic [7:0]    log_cmd[$], rd_got[$], wr_got[$], rd_bytes[$], stat_q[$], pp_data[$];
  logic [AW-1:0] log_addr[$];
  logic [11:0]   log_len[$];
  logic          log_co[$];
  int            log_cyc[$];
  logic [7:0]    stat_dflt = 8'h00;
  bit            mute = 1'b0;

  always @(posedge clk) cyc++;

  // monitor: master-side starts and user-side strobes
  always @(negedge clk) begin
    if (m_start === 1'b1) begin
      log_cmd.push_back(m_cmd); log_addr.push_back(m_addr);
      log_len.push_back(m_length); log_co.push_back(m_cmd_only); log_cyc.push_back(cyc);
    end
    if (usr_rd_vld === 1'b1) rd_got.push_back(usr_rd_data);
    if (usr_done === 1'b1) done_cnt++;
  end

  // user program-data feeder: byte valid the cycle after usr_wr_req
  always @(posedge clk) begin
    logic q;
    q = usr_wr_req;
    #1;
    if (q === 1'b1) begin
      usr_wr_data = (wr_idx < pp_data.size()) ? pp_data[wr_idx] : 8'hFF;
      wr_idx++;
    end else
      usr_wr_data = 8'h00;
  end

  // SPI master model
  always begin
    logic [7:0] c;
    int n;
    @(negedge clk);
    if (m_start === 1'b1 && !mute && !rst) begin
      c = m_cmd; n = int'(m_length);
      @(negedge clk); m_busy = 1'b1;
      if (c == 8'h03) begin
        for (int i = 0; i < n; i++) begin
          @(negedge clk); m_rd_data = (i < rd_bytes.size()) ? rd_bytes[i] : 8'hEE; m_rd_vld = 1'b1;
          @(negedge clk); m_rd_vld = 1'b0;
        end
      end else if (c == 8'h02) begin
        for (int i = 0; i < n; i++) begin
          @(negedge clk); m_wr_req = 1'b1;
          @(negedge clk); wr_got.push_back(m_wr_data); m_wr_req = 1'b0;
        end
      end else if (c == 8'h05) begin
        @(negedge clk); m_rd_data = (stat_q.size() > 0) ? stat_q.pop_front() : stat_dflt; m_rd_vld = 1'b1;
        @(negedge clk); m_rd_vld = 1'b0;
      end
      @(negedge clk); m_busy = 1'b0;
    end
  end

  task automatic clear_logs();
    log_cmd.delete(); log_addr.delete(); log_len.delete(); log_co.delete(); log_cyc.delete();
    rd_got.delete(); wr_got.delete(); done_cnt = 0; wr_idx = 0;
  endtask

  task automatic do_start(input logic [1:0] op, input logic [AW-1:0] a, input logic [11:0] len);
    @(negedge clk); usr_op = op; usr_addr = a; usr_length = len; usr_start = 1'b1;
    @(negedge clk); usr_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int took);
    took = 0;
    while (took < budget) begin
      @(negedge clk); took++;
      if (usr_done === 1'b1) break;
    end
    #1;
  endtask

  function automatic logic [31:0] pk(input logic [7:0] q[$]);
    logic [31:0] v = '0;
    foreach (q[i]) v = {v[23:0], q[i]};
    return v;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({m_start, m_cmd, m_addr, m_length, m_cmd_only, usr_busy, usr_done, usr_err,
         usr_status, usr_rd_vld, usr_rd_data, usr_wr_req} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: outputs nonzero under reset (m_cmd=%h busy=%b)", m_cmd, usr_busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    int t;
    clear_logs(); rd_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_start(2'd0, 24'h001000, 12'd4);
    wait_done(200, t);
    n_vec++; if (t >= 200) begin n_bad++; $display("FAIL read_done: no usr_done within %0d cycles", t); end
    n_vec++; if (log_cmd.size() != 1) begin n_bad++; $display("FAIL read_nstart: got %0d m_start want 1", log_cmd.size()); end
    else begin
      n_vec++; if ({log_cmd[0], log_addr[0], log_len[0], log_co[0]} !== {8'h03, 24'h001000, 12'd4, 1'b0}) begin
        n_bad++; $display("FAIL read_cmd: got cmd %h addr %h len %0d co %b want 03 001000 4 0", log_cmd[0], log_addr[0], log_len[0], log_co[0]); end
    end
    n_vec++; if (rd_got.size() != 4 || pk(rd_got) !== 32'hA1B2C3D4) begin
      n_bad++; $display("FAIL read_data: got %0d bytes %h want A1B2C3D4", rd_got.size(), pk(rd_got)); end
    n_vec++; if (usr_err !== 1'b0 || done_cnt != 1) begin
      n_bad++; $display("FAIL read_status: got err %b done %0d want 0 1", usr_err, done_cnt); end
    @(negedge clk); #1;
    n_vec++; if (usr_busy !== 1'b0) begin n_bad++; $display("FAIL read_busy_clear: got busy %b want 0", usr_busy); end
  endtask

  task automatic test_pp();
    int t;
    clear_logs(); pp_data = '{8'h5A, 8'hA5}; stat_q = '{8'h03, 8'h03, 8'h00};
    do_start(2'd1, 24'h000100, 12'd2);
    wait_done(1000, t);
    n_vec++; if (t >= 1000) begin n_bad++; $display("FAIL pp_done: no usr_done within %0d cycles", t); end
    n_vec++; if (log_cmd.size() != 5) begin n_bad++; $display("FAIL pp_nstart: got %0d m_start want 5", log_cmd.size()); end
    else begin
      n_vec++; if ({log_cmd[0], log_co[0], log_cmd[1], log_co[1], log_len[1], log_addr[1]} !==
                   {8'h06, 1'b1, 8'h02, 1'b0, 12'd2, 24'h000100}) begin
        n_bad++; $display("FAIL pp_seq: got %h/%b %h/%b len %0d addr %h want 06/1 02/0 len 2 addr 000100",
                          log_cmd[0], log_co[0], log_cmd[1], log_co[1], log_len[1], log_addr[1]); end
      n_vec++; if ({log_cmd[2], log_cmd[3], log_cmd[4], log_len[2], log_co[2]} !== {24'h050505, 12'd1, 1'b0}) begin
        n_bad++; $display("FAIL pp_polls: got %h %h %h len %0d want 05 05 05 len 1", log_cmd[2], log_cmd[3], log_cmd[4], log_len[2]); end
      n_vec++; if (log_cyc[3] - log_cyc[2] < GAP || log_cyc[4] - log_cyc[3] < GAP) begin
        n_bad++; $display("FAIL pp_gap: got spacing %0d %0d want >= %0d", log_cyc[3] - log_cyc[2], log_cyc[4] - log_cyc[3], GAP); end
    end
    n_vec++; if (wr_idx != 2 || wr_got.size() != 2 || pk(wr_got) !== 32'h00005AA5) begin
      n_bad++; $display("FAIL pp_wdata: got %0d req bytes %h want 2 5AA5", wr_idx, pk(wr_got)); end
    n_vec++; if (usr_status !== 8'h00 || usr_err !== 1'b0 || rd_got.size() != 0) begin
      n_bad++; $display("FAIL pp_status: got status %h err %b fwd %0d want 00 0 0", usr_status, usr_err, rd_got.size()); end
  endtask

  task automatic test_se_timeout();
    int t, np;
    clear_logs(); stat_dflt = 8'h01; np = 0;
    do_start(2'd2, 24'h020000, 12'd0);
    wait_done(2000, t);
    foreach (log_cmd[i]) if (log_cmd[i] == 8'h05) np++;
    n_vec++; if (t >= 2000) begin n_bad++; $display("FAIL se_done: no usr_done within %0d cycles", t); end
    n_vec++; if (np != PMAX || log_cmd.size() != PMAX + 2) begin
      n_bad++; $display("FAIL se_polls: got %0d polls %0d starts want %0d %0d", np, log_cmd.size(), PMAX, PMAX + 2); end
    else begin
      n_vec++; if ({log_cmd[1], log_len[1], log_addr[1]} !== {8'h20, 12'd0, 24'h020000}) begin
        n_bad++; $display("FAIL se_cmd: got %h len %0d addr %h want 20 0 020000", log_cmd[1], log_len[1], log_addr[1]); end
    end
    n_vec++; if (usr_err !== 1'b1 || usr_status !== 8'h01) begin
      n_bad++; $display("FAIL se_err: got err %b status %h want 1 01", usr_err, usr_status); end
    stat_dflt = 8'h00;
  endtask

  task automatic test_bad_len();
    int t;
    logic [11:0] lens [2] = '{12'd0, 12'd300};
    foreach (lens[k]) begin
      clear_logs();
      do_start(2'd1, 24'h000000, lens[k]);
      wait_done(10, t);
      n_vec++; if (t > 2 || usr_err !== 1'b1 || log_cmd.size() != 0) begin
        n_bad++; $display("FAIL bad_len_%0d: got took %0d err %b starts %0d want <=2 1 0", lens[k], t, usr_err, log_cmd.size()); end
    end
  endtask

  task automatic test_back_to_back();
    int t;
    clear_logs(); rd_bytes = '{8'h11, 8'h22};
    do_start(2'd0, 24'h00ABCD, 12'd2);
    repeat (2) @(negedge clk);
    do_start(2'd3, 24'h000000, 12'd0);
    wait_done(200, t);
    repeat (20) @(negedge clk); #1;
    n_vec++; if (log_cmd.size() != 1 || done_cnt != 1) begin
      n_bad++; $display("FAIL b2b_count: got %0d starts %0d dones want 1 1", log_cmd.size(), done_cnt); end
    n_vec++; if (rd_got.size() != 2 || pk(rd_got) !== 32'h00001122 || usr_err !== 1'b0) begin
      n_bad++; $display("FAIL b2b_data: got %0d bytes %h err %b want 2 1122 0", rd_got.size(), pk(rd_got), usr_err); end
  endtask

  task automatic test_hs_timeout();
    int t;
    clear_logs(); mute = 1'b1;
    do_start(2'd3, 24'h000000, 12'd0);
    wait_done(40, t);
    mute = 1'b0;
    n_vec++; if (t >= 40 || usr_err !== 1'b1 || log_cmd.size() != 1 || rd_got.size() != 0) begin
      n_bad++; $display("FAIL hs_timeout: got took %0d err %b starts %0d want <40 1 1", t, usr_err, log_cmd.size()); end
  endtask

  task automatic test_rst_mid();
    int t;
    clear_logs(); stat_dflt = 8'h01;
    do_start(2'd2, 24'h030000, 12'd0);
    t = 0;
    while (t < 300 && !(log_cmd.size() > 0 && log_cmd[log_cmd.size()-1] == 8'h05)) begin
      @(negedge clk); #1; t++;
    end
    n_vec++; if (t >= 300) begin n_bad++; $display("FAIL rst_mid_poll: no RDSR seen within %0d cycles", t); end
    rst = 1'b1; #1;
    n_vec++;
    if ({m_start, m_cmd, m_addr, m_length, m_cmd_only, usr_busy, usr_done, usr_err,
         usr_status, usr_rd_vld, usr_rd_data, usr_wr_req, m_wr_data} !== '0) begin
      n_bad++; $display("FAIL rst_mid_outputs: got m_start %b m_cmd %h busy %b status %h want all 0", m_start, m_cmd, usr_busy, usr_status); end
    repeat (8) @(negedge clk);
    stat_dflt = 8'h00; rst = 1'b0;
    clear_logs(); stat_q = '{8'h3C};
    do_start(2'd3, 24'h000000, 12'd0);
    wait_done(100, t);
    n_vec++; if (t >= 100 || rd_got.size() != 1 || pk(rd_got) !== 32'h0000003C || usr_status !== 8'h3C || usr_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_rdsr: got took %0d n %0d byte %h status %h err %b want 1 3C 3C 0", t, rd_got.size(), pk(rd_got), usr_status, usr_err); end
    n_vec++; if (log_cmd.size() != 1 || log_cmd[0] != 8'h05 || log_len[0] != 12'd1) begin
      n_bad++; $display("FAIL rst_mid_cmd: got %0d starts want one 05 len 1", log_cmd.size()); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_pp();
    test_se_timeout();
    test_bad_len();
    test_back_to_back();
    test_hs_timeout();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
